// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: drives the req/gnt/rvalid data bus, lanes and load extension.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TO_W           = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        bus_err_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_load;
    logic [2:0]      r_op;
    logic [1:0]      r_off;
    logic            r_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [31:0]     r_ld;
    logic            r_lv;
    logic            r_err;

    logic            w_b;
    logic            w_h;
    logic            w_req;
    logic            w_to;
    logic [1:0]      w_off;
    logic [3:0]      w_be;
    logic [31:0]     w_wd;
    logic [31:0]     w_sh;
    logic [31:0]     w_ext;

    assign w_b   = (mem_op_i[1:0] == 2'b00);
    assign w_h   = (mem_op_i[1:0] == 2'b01);
    assign w_req = mem_rd_i | mem_wr_i;
    assign w_to  = TO_EN && (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // H and W ignore the low address bits they cannot honour
    always_comb begin
        w_off = 2'b00;
        w_be  = 4'b1111;
        w_wd  = wdata_i;
        unique case (1'b1)
            w_b: begin
                w_off = addr_i[1:0];
                w_be  = 4'b0001 << w_off;
                w_wd  = {4{wdata_i[7:0]}};
            end
            w_h: begin
                w_off = {addr_i[1], 1'b0};
                w_be  = 4'b0011 << w_off;
                w_wd  = {2{wdata_i[15:0]}};
            end
            default: begin
                w_off = 2'b00;
                w_be  = 4'b1111;
                w_wd  = wdata_i;
            end
        endcase
    end

    always_comb begin
        w_sh  = dbus_rdata_i >> {r_off, 3'b000};
        w_ext = w_sh;
        unique case (1'b1)
            r_op[1:0] == 2'b00:
                w_ext = {{24{~r_op[2] & w_sh[7]}}, w_sh[7:0]};
            r_op[1:0] == 2'b01:
                w_ext = {{16{~r_op[2] & w_sh[15]}}, w_sh[15:0]};
            default:
                w_ext = w_sh;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misal;
    logic r_mis;

    assign w_misal = (w_h & addr_i[0])
                   | (~w_b & ~w_h & (|addr_i[1:0]));
    assign misalign_o = r_mis;
`else
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_load  <= 1'b0;
            r_op    <= 3'b000;
            r_off   <= 2'b00;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_ld    <= '0;
            r_lv    <= 1'b0;
            r_err   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_mis   <= 1'b0;
`endif
        end else begin
            r_lv  <= 1'b0;
            r_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_mis <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        if (w_misal) begin
                            r_state <= S_DONE;
                            r_mis   <= 1'b1;
                            if (mem_rd_i) begin
                                r_lv <= 1'b1;
                                r_ld <= '0;
                            end
                        end else
`endif
                        begin
                            r_state <= S_REQ;
                            r_cnt   <= '0;
                            r_req   <= 1'b1;
                            r_we    <= ~mem_rd_i;
                            r_load  <= mem_rd_i;
                            r_op    <= mem_op_i;
                            r_off   <= w_off;
                            r_addr  <= {addr_i[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wd;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (dbus_gnt_i && (!r_load || dbus_rvalid_i)) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                        if (r_load) begin
                            r_ld <= w_ext;
                            r_lv <= 1'b1;
                        end
                    end else if (w_to) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                        if (r_load) begin
                            r_ld <= '0;
                            r_lv <= 1'b1;
                        end
                    end else if (dbus_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + TO_W'(1);
                    if (dbus_rvalid_i) begin
                        r_ld    <= w_ext;
                        r_lv    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_to) begin
                        r_err   <= 1'b1;
                        r_ld    <= '0;
                        r_lv    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_o = ((r_state == S_IDLE) && w_req)
                   || (r_state == S_REQ)
                   || (r_state == S_WAIT);

    assign dbus_req_o   = r_req;
    assign dbus_we_o    = r_we;
    assign dbus_addr_o  = r_addr;
    assign dbus_be_o    = r_be;
    assign dbus_wdata_o = r_wdata;
    assign load_data_o  = r_ld;
    assign load_valid_o = r_lv;
    assign bus_err_o    = r_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a transaction-level timing/data model.
// Follows MEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_stage_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_rd_i = 1'b0;
    logic        mem_wr_i = 1'b0;
    logic [2:0]  mem_op_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i = 1'b0;
    logic        dbus_rvalid_i = 1'b0;
    logic [31:0] dbus_rdata_i = '0;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        bus_err_o;
    logic        misalign_o;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
        .mem_op_i(mem_op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
        .stall_o(stall_o), .load_data_o(load_data_o),
        .load_valid_o(load_valid_o), .bus_err_o(bus_err_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          lv;
        bit          err;
        bit          mis;
        logic [31:0] ld;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail = 0;
    int n_stall = 0;
    int n_req = 0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_wd = '0;
    logic [31:0] s_ld = '0;
    logic [3:0]  s_be = '0;
    logic        s_we = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int m_off(input logic [2:0] op, input logic [31:0] a);
        int lo = int'(a % 4);
        if (m_size(op) == 1) return lo;
        if (m_size(op) == 2) return (lo >= 2) ? 2 : 0;
        return 0;
    endfunction

    function automatic bit m_mis(input logic [2:0] op, input logic [31:0] a);
        int lo = int'(a % 4);
        return (m_size(op) == 2 && (lo % 2) != 0) || (m_size(op) == 4 && lo != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
        return 4'(((1 << m_size(op)) - 1) << m_off(op, a));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] op, input logic [31:0] d);
        int sz = m_size(op);
        longint unit = longint'(d) % (longint'(1) << (8 * sz));
        longint w = 0;
        for (int i = 0; i < 4 / sz; i++) w = w + (unit << (8 * sz * i));
        return 32'(w);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] d);
        int sz = m_size(op);
        longint v = longint'(d) >> (8 * m_off(op, a));
        if (sz == 4) return d;
        v = v % (longint'(1) << (8 * sz));
        if (!op[2] && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    // One cycle: compare against the model at the falling edge, then step
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (stall_o) n_stall++;
        if (dbus_req_o) begin
            n_req++;
            s_addr = dbus_addr_o;
            s_be = dbus_be_o;
            s_wd = dbus_wdata_o;
            s_we = dbus_we_o;
        end
        if (load_valid_o) s_ld = load_data_o;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("stall", stall_o, e.stall);
            chk("req", dbus_req_o, e.req);
            if (e.req) begin
                chk("addr", dbus_addr_o, e.addr);
                chk("be", dbus_be_o, e.be);
                chk("wdata", dbus_wdata_o, e.wd);
                chk("we", dbus_we_o, e.we);
            end
            chk("load_valid", load_valid_o, e.lv);
            chk("bus_err", bus_err_o, e.err);
            chk("misalign", misalign_o, e.mis);
            if (e.lv) chk("load_data", load_data_o, e.ld);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e.stall = 0; e.req = 0; e.we = 0; e.addr = '0; e.be = '0;
        e.wd = '0; e.lv = 0; e.err = 0; e.mis = 0; e.ld = '0;
        return e;
    endfunction

    // gdly: REQ cycles before gnt (-1 never); rdly: cycles from gnt to rvalid
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gdly, input int rdly,
                           input logic [31:0] rdat);
        exp_t e;
        bit ld = rd;
        bit trap = 0;
        bit to = 0;
        int nbc;
        int nb;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = m_mis(op, a);
`endif
        if (trap) nb = 0;
        else begin
            if (gdly < 0) nbc = 1000;
            else if (!ld) nbc = gdly + 1;
            else if (rdly < 0) nbc = 1000;
            else nbc = gdly + rdly + 1;
            to = (nbc > T);
            nb = to ? T : nbc;
        end
        e = idle_rec();
        e.stall = 1;
        q.push_back(e);
        for (int k = 1; k <= nb; k++) begin
            e = idle_rec();
            e.stall = 1;
            e.req = (gdly < 0) || (k <= gdly + 1);
            e.we = !ld;
            e.addr = a - (a % 4);
            e.be = m_be(op, a);
            e.wd = m_wd(op, wd);
            q.push_back(e);
        end
        e = idle_rec();
        e.lv = ld;
        e.err = to;
        e.mis = trap;
        e.ld = (to || trap) ? 32'h0 : m_load(op, a, rdat);
        q.push_back(e);
        q.push_back(idle_rec());

        mem_rd_i = rd; mem_wr_i = wr; mem_op_i = op;
        addr_i = a; wdata_i = wd;
        for (int k = 0; k <= nb + 1; k++) begin
            dbus_gnt_i = (k >= 1) && (k <= nb) && (gdly >= 0) && (k == gdly + 1);
            dbus_rvalid_i = ld && (k >= 1) && (k <= nb) && (gdly >= 0)
                            && (rdly >= 0) && (k == gdly + 1 + rdly);
            dbus_rdata_i = dbus_rvalid_i ? rdat : 32'h5A5A_5A5A;
            tick();
        end
        mem_rd_i = 0; mem_wr_i = 0;
        dbus_gnt_i = 0; dbus_rvalid_i = 0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0;
        int r0;
        #12;
        chk("rst_req", dbus_req_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_addr", dbus_addr_o, 0);
        chk("rst_be", dbus_be_o, 0);
        chk("rst_wdata", dbus_wdata_o, 0);
        chk("rst_we", dbus_we_o, 0);
        chk("rst_ld", load_data_o, 0);
        chk("rst_lv", load_valid_o, 0);
        chk("rst_err", bus_err_o, 0);
        chk("rst_mis", misalign_o, 0);
        @(posedge clk); #1;
        rstn = 1;
        tick();

        s0 = n_stall;
        run_txn(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, 0, 0);
        chk("sw_addr", s_addr, 32'h100);
        chk("sw_be", s_be, 4'b1111);
        chk("sw_wd", s_wd, 32'hDEAD_BEEF);
        chk("sw_we", s_we, 1);
        chk("sw_stall_cycles", n_stall - s0, 4);

        run_txn(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 0, 0, 0);
        chk("sb_be", s_be, 4'b1000);
        chk("sb_wd", s_wd, 32'hA5A5_A5A5);
        chk("sb_addr", s_addr, 32'h200);

        run_txn(1, 0, 3'b000, 32'h302, 0, 0, 3, 32'h0080_0000);
        chk("lb_data", s_ld, 32'hFFFF_FF80);
        run_txn(1, 0, 3'b100, 32'h302, 0, 0, 3, 32'h0080_0000);
        chk("lbu_data", s_ld, 32'h0000_0080);

        s0 = n_stall;
        run_txn(1, 0, 3'b001, 32'h400, 0, 0, 0, 32'h1234_8001);
        chk("lh_data", s_ld, 32'hFFFF_8001);
        chk("lh_stall_cycles", n_stall - s0, 2);

        run_txn(1, 0, 3'b101, 32'h402, 0, 1, 1, 32'h8001_7FFF);
        chk("lhu_data", s_ld, 32'h0000_8001);
        run_txn(1, 0, 3'b010, 32'h404, 0, 1, 0, 32'hCAFE_F00D);
        chk("lw_data", s_ld, 32'hCAFE_F00D);
        run_txn(0, 1, 3'b001, 32'h406, 32'h1234_ABCD, 1, 0, 0);
        chk("sh_be", s_be, 4'b1100);
        chk("sh_wd", s_wd, 32'hABCD_ABCD);
        run_txn(0, 1, 3'b011, 32'h408, 32'h0BAD_F00D, 0, 0, 0);
        chk("undef_be", s_be, 4'b1111);
        run_txn(1, 1, 3'b000, 32'h40D, 0, 0, 1, 32'h0000_7F00);
        chk("rdwr_we", s_we, 0);
        chk("rdwr_data", s_ld, 32'h0000_007F);

        s0 = n_stall;
        run_txn(1, 0, 3'b010, 32'h440, 0, -1, -1, 0);
        chk("to_ld_stall_cycles", n_stall - s0, 1 + T);
        chk("to_ld_data", s_ld, 32'h0);
        run_txn(0, 1, 3'b010, 32'h444, 32'h1111_2222, -1, 0, 0);
        run_txn(1, 0, 3'b000, 32'h448, 0, 2, -1, 0);

        s0 = n_stall;
        r0 = n_req;
        run_txn(1, 0, 3'b010, 32'h502, 0, 0, 0, 32'h0F0F_0F0F);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req_cycles", n_req - r0, 0);
        chk("mis_stall_cycles", n_stall - s0, 1);
`else
        chk("mis_addr", s_addr, 32'h500);
        chk("mis_be", s_be, 4'b1111);
        chk("mis_data", s_ld, 32'h0F0F_0F0F);
`endif

        mem_rd_i = 1; mem_op_i = 3'b010; addr_i = 32'h600;
        tick();
        tick();
        chk("mid_req_before", dbus_req_o, 1);
        #1;
        rstn = 0;
        mem_rd_i = 0;
        #1;
        chk("mid_rst_req", dbus_req_o, 0);
        chk("mid_rst_stall", stall_o, 0);
        chk("mid_rst_lv", load_valid_o, 0);
        @(posedge clk); #1;
        rstn = 1;
        q.push_back(idle_rec());
        q.push_back(idle_rec());
        dbus_rvalid_i = 1;
        dbus_rdata_i = 32'hDEAD_BEEF;
        tick();
        tick();
        dbus_rvalid_i = 0;

        run_txn(1, 0, 3'b001, 32'h702, 0, 1, 2, 32'hF00D_1234);
        chk("post_rst_data", s_ld, 32'hFFFF_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
